// File: rtl/axi_aw_alloc_pkg.sv
// ---------------------------------------------------------------------------
// axi_aw_alloc_pkg
// Shared types for the AW allocator slice.
//   arb_mode_e : arbitration policy (round-robin or fixed lowest-index)
//   state_e    : allocator FSM states (IDLE/LOCKED for the combinational
//                path, IDLE/FULL for the registered output stage)
//   aw_ctrl_t  : the fixed-width AW control fields, bundled so they can be
//                muxed and registered as one unit
// ---------------------------------------------------------------------------
package axi_aw_alloc_pkg;

    typedef enum logic {
        RR,
        FIXED
    } arb_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        FULL
    } state_e;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] region;
        logic [3:0] qos;
    } aw_ctrl_t;

    // Pointer that follows an accepted winner, wrapping N-1 back to 0.
    function automatic int unsigned next_rr_ptr(int unsigned win, int unsigned n);
        return (win + 1 >= n) ? 0 : win + 1;
    endfunction

endpackage

// File: rtl/axi_masked_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_masked_rr_arbiter
// Purely combinational N-way arbiter. Requests that are masked are never
// granted. In RR mode the search starts at ptr and wraps; in FIXED mode the
// lowest eligible index wins and ptr is ignored.
// Ports:
//   req        in   N    request vector
//   mask       in   N    1 = requester blocked this cycle
//   ptr        in   LOG  round-robin start index
//   gnt_onehot out  N    one-hot winner (zero when nothing eligible)
//   gnt_bin    out  LOG  binary winner index
//   gnt_valid  out  1    some requester won
// ---------------------------------------------------------------------------
module axi_masked_rr_arbiter
    import axi_aw_alloc_pkg::*;
#(
    parameter int        N    = 4,
    parameter int        LOG  = $clog2(N),
    parameter arb_mode_e MODE = RR
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [LOG-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [LOG-1:0] gnt_bin,
    output logic           gnt_valid
);

    logic [N-1:0] eligible;

    assign eligible = req & ~mask;

    // Walk the candidates in priority order and keep the first eligible one.
    always_comb begin : p_search
        int idx;
        gnt_onehot = '0;
        gnt_bin    = '0;
        gnt_valid  = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            if (MODE == RR) begin
                idx = (int'(ptr) + k) % N;
            end else begin
                idx = k;
            end
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid       = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_bin         = LOG'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_aw_arbiter_qos.sv
// ---------------------------------------------------------------------------
// axi_aw_arbiter_qos
// Write-address allocator for one AXI slave port. Arbitrates N_TARG_PORT
// master AW channels, tags AWID with the winner's binary index, pushes the
// {bin,onehot} ID once per burst to the write-data allocator, and limits the
// number of outstanding (un-responded) writes per master.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   aw*_i              per-master AW payload (packed [N][w])
//   awvalid_i          per-master AW valid
//   awready_o          per-master AW ready (one-hot or zero)
//   aw*_o              arbitrated AW payload, awid_o = {bin, awid_i[win]}
//   awvalid_o/awready_i downstream AW handshake
//   push_id_o, id_o    ID push to the DW FIFO, id_fifo_gnt_i = FIFO has room
//   b_done_i           one-hot pulse: B response returned to master i
//   outst_full_o       master i has MAX_OUTST writes outstanding
// ---------------------------------------------------------------------------
module axi_aw_arbiter_qos
    import axi_aw_alloc_pkg::*;
#(
    parameter int        AXI_ADDRESS_W = 32,
    parameter int        AXI_USER_W    = 6,
    parameter int        N_TARG_PORT   = 7,
    parameter int        LOG_N_TARG    = $clog2(N_TARG_PORT),
    parameter int        AXI_ID_IN     = 16,
    parameter int        AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG,
    parameter arb_mode_e ARB_MODE      = RR,
    parameter int        MAX_OUTST     = 8,
    parameter bit        REG_OUT       = 1'b0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]       awid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0]   awaddr_i,
    input  logic [N_TARG_PORT-1:0][7:0]                 awlen_i,
    input  logic [N_TARG_PORT-1:0][2:0]                 awsize_i,
    input  logic [N_TARG_PORT-1:0][1:0]                 awburst_i,
    input  logic [N_TARG_PORT-1:0]                      awlock_i,
    input  logic [N_TARG_PORT-1:0][3:0]                 awcache_i,
    input  logic [N_TARG_PORT-1:0][2:0]                 awprot_i,
    input  logic [N_TARG_PORT-1:0][3:0]                 awregion_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]      awuser_i,
    input  logic [N_TARG_PORT-1:0][3:0]                 awqos_i,
    input  logic [N_TARG_PORT-1:0]                      awvalid_i,
    output logic [N_TARG_PORT-1:0]                      awready_o,
    output logic [AXI_ID_OUT-1:0]                       awid_o,
    output logic [AXI_ADDRESS_W-1:0]                    awaddr_o,
    output logic [7:0]                                  awlen_o,
    output logic [2:0]                                  awsize_o,
    output logic [1:0]                                  awburst_o,
    output logic                                        awlock_o,
    output logic [3:0]                                  awcache_o,
    output logic [2:0]                                  awprot_o,
    output logic [3:0]                                  awregion_o,
    output logic [AXI_USER_W-1:0]                       awuser_o,
    output logic [3:0]                                  awqos_o,
    output logic                                        awvalid_o,
    input  logic                                        awready_i,
    output logic                                        push_id_o,
    output logic [LOG_N_TARG+N_TARG_PORT-1:0]           id_o,
    input  logic                                        id_fifo_gnt_i,
    input  logic [N_TARG_PORT-1:0]                      b_done_i,
    output logic [N_TARG_PORT-1:0]                      outst_full_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [N_TARG_PORT-1:0][CNT_W-1:0] cnt_q;
    logic [N_TARG_PORT-1:0]            full;
    logic [N_TARG_PORT-1:0]            cnt_inc;
    logic [N_TARG_PORT-1:0]            cnt_dec;
    logic [N_TARG_PORT-1:0]            arb_gnt;
    logic [LOG_N_TARG-1:0]             arb_bin;
    logic                              arb_valid;
    logic [LOG_N_TARG-1:0]             rr_ptr_q;
    aw_ctrl_t [N_TARG_PORT-1:0]        ctrl_in;
    logic                              accept;
    logic [LOG_N_TARG-1:0]             accept_bin;
    logic [AXI_ID_OUT-1:0]             out_id;
    logic [AXI_ADDRESS_W-1:0]          out_addr;
    aw_ctrl_t                          out_ctrl;
    logic [AXI_USER_W-1:0]             out_user;

    // Bundle the fixed-width control fields per master so one mux serves all.
    always_comb begin
        for (int i = 0; i < N_TARG_PORT; i++) begin
            ctrl_in[i] = '{len:    awlen_i[i],
                           size:   awsize_i[i],
                           burst:  awburst_i[i],
                           lock:   awlock_i[i],
                           cache:  awcache_i[i],
                           prot:   awprot_i[i],
                           region: awregion_i[i],
                           qos:    awqos_i[i]};
        end
    end

    // Masters at their outstanding limit are masked out of arbitration.
    axi_masked_rr_arbiter #(
        .N    (N_TARG_PORT),
        .LOG  (LOG_N_TARG),
        .MODE (ARB_MODE)
    ) u_arb (
        .req        (awvalid_i),
        .mask       (full),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_gnt),
        .gnt_bin    (arb_bin),
        .gnt_valid  (arb_valid)
    );

    // The ID FIFO entry always describes the current arbitration winner; it
    // is only meaningful in the cycle push_id_o is high.
    assign id_o = {arb_bin, arb_gnt};

    assign awid_o     = out_id;
    assign awaddr_o   = out_addr;
    assign awlen_o    = out_ctrl.len;
    assign awsize_o   = out_ctrl.size;
    assign awburst_o  = out_ctrl.burst;
    assign awlock_o   = out_ctrl.lock;
    assign awcache_o  = out_ctrl.cache;
    assign awprot_o   = out_ctrl.prot;
    assign awregion_o = out_ctrl.region;
    assign awuser_o   = out_user;
    assign awqos_o    = out_ctrl.qos;

    generate
        if (REG_OUT == 1'b0) begin : gen_comb_path
            state_e                 state_q, state_d;
            logic [LOG_N_TARG-1:0]  win_q;
            logic [N_TARG_PORT-1:0] win_oh_q;
            logic [LOG_N_TARG-1:0]  sel;

            // State register; the winner is latched only when the slave stalls
            // the first cycle, so LOCKED can replay the same master.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q  <= IDLE;
                    win_q    <= '0;
                    win_oh_q <= '0;
                end else begin
                    state_q <= state_d;
                    if (state_q == IDLE && arb_valid && id_fifo_gnt_i && !awready_i) begin
                        win_q    <= arb_bin;
                        win_oh_q <= arb_gnt;
                    end
                end
            end

            // awvalid_o depends only on state and master requests, never on
            // awready_i, so the slave sees no combinational loop.
            always_comb begin
                state_d   = state_q;
                awvalid_o = 1'b0;
                awready_o = '0;
                push_id_o = 1'b0;
                accept    = 1'b0;
                sel       = arb_bin;
                case (state_q)
                    IDLE: begin
                        if (arb_valid && id_fifo_gnt_i) begin
                            awvalid_o = 1'b1;
                            push_id_o = 1'b1;
                            if (awready_i) begin
                                awready_o = arb_gnt;
                                accept    = 1'b1;
                            end else begin
                                state_d = LOCKED;
                            end
                        end
                    end
                    LOCKED: begin
                        sel       = win_q;
                        awvalid_o = 1'b1;
                        if (awready_i) begin
                            awready_o = win_oh_q;
                            accept    = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            assign accept_bin = sel;
            assign out_id     = {sel, awid_i[sel]};
            assign out_addr   = awaddr_i[sel];
            assign out_ctrl   = ctrl_in[sel];
            assign out_user   = awuser_i[sel];

            // A locked master must keep AWVALID up until the slave takes it.
            a_hold_valid: assert property (@(posedge clk) disable iff (rst)
                (state_q == LOCKED) |-> ((awvalid_i & win_oh_q) != '0));

        end else begin : gen_reg_path
            state_e                   state_q, state_d;
            logic                     capture;
            logic [AXI_ID_OUT-1:0]    id_q;
            logic [AXI_ADDRESS_W-1:0] addr_q;
            aw_ctrl_t                 ctrl_q;
            logic [AXI_USER_W-1:0]    user_q;

            // Capture happens from IDLE, or from FULL in the same cycle the
            // slave drains the register, giving one AW per cycle throughput.
            always_comb begin
                state_d = state_q;
                capture = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (arb_valid && id_fifo_gnt_i) begin
                            capture = 1'b1;
                            state_d = FULL;
                        end
                    end
                    FULL: begin
                        if (awready_i) begin
                            if (arb_valid && id_fifo_gnt_i) begin
                                capture = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
                awvalid_o = (state_q == FULL);
                awready_o = capture ? arb_gnt : '0;
                push_id_o = capture;
                accept    = capture;
            end

            // Output stage register; payload holds while the slave stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    id_q    <= '0;
                    addr_q  <= '0;
                    ctrl_q  <= '0;
                    user_q  <= '0;
                end else begin
                    state_q <= state_d;
                    if (capture) begin
                        id_q   <= {arb_bin, awid_i[arb_bin]};
                        addr_q <= awaddr_i[arb_bin];
                        ctrl_q <= ctrl_in[arb_bin];
                        user_q <= awuser_i[arb_bin];
                    end
                end
            end

            assign accept_bin = arb_bin;
            assign out_id     = id_q;
            assign out_addr   = addr_q;
            assign out_ctrl   = ctrl_q;
            assign out_user   = user_q;
        end
    endgenerate

    // Round-robin pointer moves past the master that was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= LOG_N_TARG'(next_rr_ptr(int'(accept_bin), N_TARG_PORT));
        end
    end

    // A response for a master with nothing outstanding is dropped so the
    // counter cannot wrap.
    always_comb begin
        for (int i = 0; i < N_TARG_PORT; i++) begin
            cnt_inc[i] = awvalid_i[i] & awready_o[i];
            cnt_dec[i] = b_done_i[i] & (cnt_q[i] != '0);
            full[i]    = (cnt_q[i] == CNT_W'(MAX_OUTST));
        end
    end

    // Outstanding-write counters; simultaneous issue and response cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_TARG_PORT; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (!cnt_inc[i] && cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    assign outst_full_o = full;

    a_bdone_nonzero: assert property (@(posedge clk) disable iff (rst)
        ((b_done_i & ~cnt_dec) == '0));

endmodule

// File: tb/tb_axi_aw_arbiter_qos.sv
// ---------------------------------------------------------------------------
// tb_axi_aw_arbiter_qos
// Directed bench: dut_a is round-robin with a combinational AW path and a
// two-write outstanding limit, driven from a per-cycle vector table.
// dut_b is fixed-priority with the registered output stage, driven by a
// short hand-written back-to-back sequence.
// ---------------------------------------------------------------------------
module tb_axi_aw_arbiter_qos;
    import axi_aw_alloc_pkg::*;

    localparam int N   = 4;
    localparam int LOG = 2;
    localparam int IDW = 16;
    localparam int AW  = 32;
    localparam int UW  = 6;

    logic clk;
    logic rst;

    logic [N-1:0][IDW-1:0] awid_i;
    logic [N-1:0][AW-1:0]  awaddr_i;
    logic [N-1:0][7:0]     awlen_i;
    logic [N-1:0][2:0]     awsize_i;
    logic [N-1:0][1:0]     awburst_i;
    logic [N-1:0]          awlock_i;
    logic [N-1:0][3:0]     awcache_i;
    logic [N-1:0][2:0]     awprot_i;
    logic [N-1:0][3:0]     awregion_i;
    logic [N-1:0][UW-1:0]  awuser_i;
    logic [N-1:0][3:0]     awqos_i;

    logic [N-1:0]       vld_a, rdy_a, bd_a, full_a;
    logic               ardy_a, gnt_a, awvalid_a, push_a, lock_a;
    logic [IDW+LOG-1:0] id_a;
    logic [AW-1:0]      addr_a;
    logic [7:0]         len_a;
    logic [2:0]         size_a, prot_a;
    logic [1:0]         burst_a;
    logic [3:0]         cache_a, region_a, qos_a;
    logic [UW-1:0]      user_a;
    logic [LOG+N-1:0]   pid_a;

    logic [N-1:0]       vld_b, rdy_b, bd_b, full_b;
    logic               ardy_b, gnt_b, awvalid_b, push_b, lock_b;
    logic [IDW+LOG-1:0] id_b;
    logic [AW-1:0]      addr_b;
    logic [7:0]         len_b;
    logic [2:0]         size_b, prot_b;
    logic [1:0]         burst_b;
    logic [3:0]         cache_b, region_b, qos_b;
    logic [UW-1:0]      user_b;
    logic [LOG+N-1:0]   pid_b;

    int total;
    int bad;

    axi_aw_arbiter_qos #(
        .AXI_ADDRESS_W (AW), .AXI_USER_W (UW), .N_TARG_PORT (N), .LOG_N_TARG (LOG),
        .AXI_ID_IN (IDW), .AXI_ID_OUT (IDW + LOG), .ARB_MODE (RR),
        .MAX_OUTST (2), .REG_OUT (1'b0)
    ) dut_a (
        .clk (clk), .rst (rst),
        .awid_i (awid_i), .awaddr_i (awaddr_i), .awlen_i (awlen_i), .awsize_i (awsize_i),
        .awburst_i (awburst_i), .awlock_i (awlock_i), .awcache_i (awcache_i),
        .awprot_i (awprot_i), .awregion_i (awregion_i), .awuser_i (awuser_i),
        .awqos_i (awqos_i), .awvalid_i (vld_a), .awready_o (rdy_a),
        .awid_o (id_a), .awaddr_o (addr_a), .awlen_o (len_a), .awsize_o (size_a),
        .awburst_o (burst_a), .awlock_o (lock_a), .awcache_o (cache_a),
        .awprot_o (prot_a), .awregion_o (region_a), .awuser_o (user_a),
        .awqos_o (qos_a), .awvalid_o (awvalid_a), .awready_i (ardy_a),
        .push_id_o (push_a), .id_o (pid_a), .id_fifo_gnt_i (gnt_a),
        .b_done_i (bd_a), .outst_full_o (full_a)
    );

    axi_aw_arbiter_qos #(
        .AXI_ADDRESS_W (AW), .AXI_USER_W (UW), .N_TARG_PORT (N), .LOG_N_TARG (LOG),
        .AXI_ID_IN (IDW), .AXI_ID_OUT (IDW + LOG), .ARB_MODE (FIXED),
        .MAX_OUTST (8), .REG_OUT (1'b1)
    ) dut_b (
        .clk (clk), .rst (rst),
        .awid_i (awid_i), .awaddr_i (awaddr_i), .awlen_i (awlen_i), .awsize_i (awsize_i),
        .awburst_i (awburst_i), .awlock_i (awlock_i), .awcache_i (awcache_i),
        .awprot_i (awprot_i), .awregion_i (awregion_i), .awuser_i (awuser_i),
        .awqos_i (awqos_i), .awvalid_i (vld_b), .awready_o (rdy_b),
        .awid_o (id_b), .awaddr_o (addr_b), .awlen_o (len_b), .awsize_o (size_b),
        .awburst_o (burst_b), .awlock_o (lock_b), .awcache_o (cache_b),
        .awprot_o (prot_b), .awregion_o (region_b), .awuser_o (user_b),
        .awqos_o (qos_b), .awvalid_o (awvalid_b), .awready_i (ardy_b),
        .push_id_o (push_b), .id_o (pid_b), .id_fifo_gnt_i (gnt_b),
        .b_done_i (bd_b), .outst_full_o (full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       ardy;
        logic       gnt;
        logic [3:0] bdone;
        logic       evld;
        logic [3:0] erdy;
        logic       epush;
        logic [1:0] ewin;
        logic [3:0] efull;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] vld, logic ardy, logic gnt,
                                logic [3:0] bd, logic ev, logic [3:0] er, logic ep,
                                logic [1:0] ew, logic [3:0] ef);
        vec_t v;
        v.rst = r; v.vld = vld; v.ardy = ardy; v.gnt = gnt; v.bdone = bd;
        v.evld = ev; v.erdy = er; v.epush = ep; v.ewin = ew; v.efull = ef;
        return v;
    endfunction

    // Expected payload of master w, as loaded into the shared payload inputs.
    function automatic logic [IDW+LOG-1:0] expId(logic [1:0] w);
        logic [IDW-1:0] base;
        base = 16'hA000 + IDW'(w);
        return {w, base};
    endfunction

    function automatic logic [AW-1:0] expAddr(logic [1:0] w);
        return 32'h1000_0000 + (AW'(w) << 8);
    endfunction

    task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        rst    = v.rst;
        vld_a  = v.vld;
        ardy_a = v.ardy;
        gnt_a  = v.gnt;
        bd_a   = v.bdone;
    endtask

    task automatic checkOutput(int row, vec_t v);
        logic [3:0] oh;
        #2;
        oh = 4'b0001 << v.ewin;
        checkVal($sformatf("row%0d.awvalid", row), 64'(awvalid_a), 64'(v.evld));
        checkVal($sformatf("row%0d.awready", row), 64'(rdy_a), 64'(v.erdy));
        checkVal($sformatf("row%0d.push", row), 64'(push_a), 64'(v.epush));
        checkVal($sformatf("row%0d.full", row), 64'(full_a), 64'(v.efull));
        if (v.evld) begin
            checkVal($sformatf("row%0d.awid", row), 64'(id_a), 64'(expId(v.ewin)));
            checkVal($sformatf("row%0d.awaddr", row), 64'(addr_a), 64'(expAddr(v.ewin)));
            checkVal($sformatf("row%0d.awlen", row), 64'(len_a), 64'(8'(v.ewin) + 8'd3));
        end
        if (v.epush) begin
            checkVal($sformatf("row%0d.id_o", row), 64'(pid_a), 64'({v.ewin, oh}));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        vld_a = '0; ardy_a = 1'b0; gnt_a = 1'b0; bd_a = '0;
        vld_b = '0; ardy_b = 1'b0; gnt_b = 1'b0; bd_b = '0;
        for (int i = 0; i < N; i++) begin
            awid_i[i]     = 16'hA000 + 16'(i);
            awaddr_i[i]   = 32'h1000_0000 + (32'(i) << 8);
            awlen_i[i]    = 8'(i) + 8'd3;
            awsize_i[i]   = 3'd2;
            awburst_i[i]  = 2'b01;
            awlock_i[i]   = 1'b0;
            awcache_i[i]  = 4'h3;
            awprot_i[i]   = 3'd0;
            awregion_i[i] = 4'(i);
            awuser_i[i]   = 6'(i + 1);
            awqos_i[i]    = 4'(i);
        end

        //             rst  vld     rdy  gnt  bdone   evld erdy    push win  full
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000));
        // round robin with everyone requesting and the slave always ready
        tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, 1, 4'b0010, 1, 2'd1, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, 1, 4'b0100, 1, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, 1, 4'b1000, 1, 2'd3, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'b0000));
        // reset is synchronous: m0's count of 2 is still visible this cycle
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0001));
        // outstanding limit on m0, then release via b_done
        tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 1, 1, 4'b0000, 1, 4'b0010, 1, 2'd1, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0001, 0, 4'b0000, 0, 2'd0, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0001));
        // m3: accept and b_done in the same cycle leaves the count at 1
        tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b0000, 1, 4'b1000, 1, 2'd3, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b1000, 1, 4'b1000, 1, 2'd3, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b0000, 1, 4'b1000, 1, 2'd3, 4'b0000));
        tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b1000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b1000));
        // ID FIFO back-pressure
        tbl.push_back(mk(0, 4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000));
        // slave stall on m2; m1 arrives mid-stall and must not steal the grant
        tbl.push_back(mk(0, 4'b0100, 0, 1, 4'b0000, 1, 4'b0000, 1, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0110, 0, 1, 4'b0000, 1, 4'b0000, 0, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0110, 0, 1, 4'b0000, 1, 4'b0000, 0, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0110, 0, 1, 4'b0000, 1, 4'b0000, 0, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0110, 0, 1, 4'b0000, 1, 4'b0000, 0, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0110, 1, 1, 4'b0000, 1, 4'b0100, 0, 2'd2, 4'b0000));
        tbl.push_back(mk(0, 4'b0010, 1, 1, 4'b0000, 1, 4'b0010, 1, 2'd1, 4'b0000));

        repeat (2) @(posedge clk);

        for (int r = 0; r < tbl.size(); r++) begin
            applyStimulus(tbl[r]);
            checkOutput(r, tbl[r]);
        end

        // Registered stage, fixed priority: m0 and m2 back-to-back.
        @(negedge clk);
        rst = 1'b0; vld_a = '0;
        vld_b = 4'b0101; ardy_b = 1'b1; gnt_b = 1'b1;
        #2;
        checkVal("regB.c0.awvalid", 64'(awvalid_b), 64'(1'b0));
        checkVal("regB.c0.awready", 64'(rdy_b), 64'(4'b0001));
        checkVal("regB.c0.push", 64'(push_b), 64'(1'b1));
        checkVal("regB.c0.id_o", 64'(pid_b), 64'({2'd0, 4'b0001}));

        @(negedge clk);
        vld_b = 4'b0100;
        #2;
        checkVal("regB.c1.awvalid", 64'(awvalid_b), 64'(1'b1));
        checkVal("regB.c1.awid", 64'(id_b), 64'(expId(2'd0)));
        checkVal("regB.c1.awaddr", 64'(addr_b), 64'(expAddr(2'd0)));
        checkVal("regB.c1.awready", 64'(rdy_b), 64'(4'b0100));
        checkVal("regB.c1.push", 64'(push_b), 64'(1'b1));
        checkVal("regB.c1.id_o", 64'(pid_b), 64'({2'd2, 4'b0100}));

        @(negedge clk);
        vld_b = 4'b0000;
        #2;
        checkVal("regB.c2.awvalid", 64'(awvalid_b), 64'(1'b1));
        checkVal("regB.c2.awid", 64'(id_b), 64'(expId(2'd2)));
        checkVal("regB.c2.awuser", 64'(user_b), 64'(6'd3));
        checkVal("regB.c2.awready", 64'(rdy_b), 64'(4'b0000));
        checkVal("regB.c2.push", 64'(push_b), 64'(1'b0));

        @(negedge clk);
        #2;
        checkVal("regB.c3.awvalid", 64'(awvalid_b), 64'(1'b0));
        checkVal("regB.c3.full", 64'(full_b), 64'(4'b0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
